// File: rtl/apb_bridge_pkg.sv
// Shared types for the APB master bridge: FSM state encoding, request/response
// bundles for upstream glue, and the PSEL index width helper.
package apb_bridge_pkg;

`ifndef APB_BRIDGE_ADDR_W
`define APB_BRIDGE_ADDR_W 32
`endif
`ifndef APB_BRIDGE_DATA_W
`define APB_BRIDGE_DATA_W 32
`endif
`ifndef APB_BRIDGE_SEL_W
`define APB_BRIDGE_SEL_W 1
`endif

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } apb_state_t;

    localparam logic [2:0] PPROT_DEFAULT = 3'b000;

    typedef struct packed {
        logic                               write;
        logic [`APB_BRIDGE_ADDR_W-1:0]      addr;
        logic [`APB_BRIDGE_DATA_W-1:0]      wdata;
        logic [`APB_BRIDGE_DATA_W/8-1:0]    strb;
        logic [2:0]                         prot;
        logic [`APB_BRIDGE_SEL_W-1:0]       sel;
    } apb_req_t;

    typedef struct packed {
        logic [`APB_BRIDGE_DATA_W-1:0]      rdata;
        logic                               err;
        logic                               timeout;
    } apb_rsp_t;

    function automatic int sel_width(input int nsel);
        return (nsel > 1) ? $clog2(nsel) : 1;
    endfunction

endpackage

// File: rtl/apb_psel_decode.sv
// Binary PSEL index to one-hot PSEL lines; indices with no matching line
// raise out_of_range and leave every PSEL low.
module apb_psel_decode #(
    parameter int NSEL  = 1,
    parameter int SEL_W = 1
) (
    input  logic [SEL_W-1:0] sel,
    output logic [NSEL-1:0]  psel,
    output logic             out_of_range
);

    always_comb begin
        psel         = '0;
        out_of_range = 1'b1;
        for (int i = 0; i < NSEL; i++) begin
            if (sel == SEL_W'(i)) begin
                psel[i]      = 1'b1;
                out_of_range = 1'b0;
            end
        end
    end

endmodule

// File: rtl/apb_master_bridge.sv
// Valid/ready command port to APB3/APB4 master, one transfer in flight.
// Optional ACCESS wait-state timeout enabled by defining KVIPS_APB_TIMEOUT_EN.
module apb_master_bridge
    import apb_bridge_pkg::*;
#(
    parameter int  ADDR_W      = 32,
    parameter int  DATA_W      = 32,
    parameter int  NSEL        = 1,
    parameter int  TIMEOUT_CYC = 256,
    localparam int STRB_W      = DATA_W / 8,
    localparam int SEL_W       = sel_width(NSEL)
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              apb4_en,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [STRB_W-1:0] req_strb,
    input  logic [2:0]        req_prot,
    input  logic [SEL_W-1:0]  req_sel,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,

    output logic [ADDR_W-1:0] PADDR,
    output logic [NSEL-1:0]   PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [DATA_W-1:0] PWDATA,
    output logic [2:0]        PPROT,
    output logic [STRB_W-1:0] PSTRB,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    apb_state_t      state;
    logic [NSEL-1:0] dec_psel;
    logic            dec_oor;
    logic            sel_oor;

    apb_psel_decode #(
        .NSEL  (NSEL),
        .SEL_W (SEL_W)
    ) u_psel_decode (
        .sel          (req_sel),
        .psel         (dec_psel),
        .out_of_range (dec_oor)
    );

    assign req_ready = (state == IDLE) && !PRESET;

`ifdef KVIPS_APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] wait_cnt;
`else
    assign rsp_timeout = 1'b0;
`endif

    // An unselected target has nobody to raise PREADY, so sel_oor lets ACCESS finish alone.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state     <= IDLE;
            PADDR     <= '0;
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PWDATA    <= '0;
            PPROT     <= '0;
            PSTRB     <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            sel_oor   <= 1'b0;
`ifdef KVIPS_APB_TIMEOUT_EN
            wait_cnt    <= '0;
            rsp_timeout <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        PADDR   <= req_addr;
                        PWRITE  <= req_write;
                        PWDATA  <= req_write ? req_wdata : '0;
                        PPROT   <= apb4_en ? req_prot : PPROT_DEFAULT;
                        PSTRB   <= !req_write ? '0 : (apb4_en ? req_strb : '1);
                        PSEL    <= dec_psel;
                        PENABLE <= 1'b0;
                        sel_oor <= dec_oor;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
`ifdef KVIPS_APB_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    state   <= ACCESS;
                end
                ACCESS: begin
                    if (PREADY || sel_oor) begin
                        PSEL      <= '0;
                        PENABLE   <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= (PWRITE || sel_oor) ? '0 : PRDATA;
                        rsp_err   <= PSLVERR || sel_oor;
`ifdef KVIPS_APB_TIMEOUT_EN
                        rsp_timeout <= 1'b0;
`endif
                        state     <= RESP;
                    end
`ifdef KVIPS_APB_TIMEOUT_EN
                    else if (wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        PSEL        <= '0;
                        PENABLE     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        state       <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge (NSEL=3, TIMEOUT_CYC=8); covers the
// KVIPS_APB_TIMEOUT_EN build when that macro is defined.
module tb_apb_master_bridge;

    logic        PCLK;
    logic        PRESET;
    logic        apb4_en;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_strb;
    logic [2:0]  req_prot;
    logic [1:0]  req_sel;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [31:0] PADDR;
    logic [2:0]  PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [2:0]  PPROT;
    logic [3:0]  PSTRB;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    int checks = 0;
    int errors = 0;

    apb_master_bridge #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .NSEL        (3),
        .TIMEOUT_CYC (8)
    ) dut (
        .PCLK        (PCLK),
        .PRESET      (PRESET),
        .apb4_en     (apb4_en),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .req_strb    (req_strb),
        .req_prot    (req_prot),
        .req_sel     (req_sel),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .PADDR       (PADDR),
        .PSEL        (PSEL),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PWDATA      (PWDATA),
        .PPROT       (PPROT),
        .PSTRB       (PSTRB),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Called on a negedge; returns on the negedge after acceptance (SETUP cycle).
    task automatic applyStimulus(input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] strb,
                                 input logic [2:0] prot, input logic [1:0] sel,
                                 input logic apb4);
        logic accepted;
        accepted  = 1'b0;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_strb  = strb;
        req_prot  = prot;
        req_sel   = sel;
        apb4_en   = apb4;
        for (int i = 0; i < 20 && !accepted; i++) begin
            if (req_ready) begin
                @(posedge PCLK);
                accepted = 1'b1;
            end else begin
                @(negedge PCLK);
            end
        end
        @(negedge PCLK);
        req_valid = 1'b0;
        checkOutput("accepted", {63'd0, accepted}, 64'd1);
    endtask

    task automatic popResponse();
        rsp_ready = 1'b1;
        @(negedge PCLK);
        rsp_ready = 1'b0;
        checkOutput("pop_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        checkOutput("pop_req_ready", {63'd0, req_ready}, 64'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        PRESET    = 1'b1;
        apb4_en   = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_strb  = '0;
        req_prot  = '0;
        req_sel   = '0;
        rsp_ready = 1'b0;
        PRDATA    = '0;
        PREADY    = 1'b1;
        PSLVERR   = 1'b0;

        // Reset values
        repeat (2) @(negedge PCLK);
        checkOutput("rst_req_ready", {63'd0, req_ready}, 64'd0);
        checkOutput("rst_PSEL", {61'd0, PSEL}, 64'd0);
        checkOutput("rst_PENABLE", {63'd0, PENABLE}, 64'd0);
        checkOutput("rst_PADDR", {32'd0, PADDR}, 64'd0);
        checkOutput("rst_PWRITE", {63'd0, PWRITE}, 64'd0);
        checkOutput("rst_PWDATA", {32'd0, PWDATA}, 64'd0);
        checkOutput("rst_PPROT", {61'd0, PPROT}, 64'd0);
        checkOutput("rst_PSTRB", {60'd0, PSTRB}, 64'd0);
        checkOutput("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        checkOutput("rst_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
        checkOutput("rst_rsp_err", {63'd0, rsp_err}, 64'd0);
        checkOutput("rst_rsp_timeout", {63'd0, rsp_timeout}, 64'd0);
        PRESET = 1'b0;
        @(negedge PCLK);
        checkOutput("idle_req_ready", {63'd0, req_ready}, 64'd1);

        // APB4 write, zero wait states, response held by rsp_ready=0
        applyStimulus(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'b0011, 3'b010, 2'd0, 1'b1);
        checkOutput("w1_setup_PSEL", {61'd0, PSEL}, 64'b001);
        checkOutput("w1_setup_PENABLE", {63'd0, PENABLE}, 64'd0);
        checkOutput("w1_PADDR", {32'd0, PADDR}, 64'h10);
        checkOutput("w1_PWRITE", {63'd0, PWRITE}, 64'd1);
        checkOutput("w1_PWDATA", {32'd0, PWDATA}, 64'hDEAD_BEEF);
        checkOutput("w1_PSTRB", {60'd0, PSTRB}, 64'b0011);
        checkOutput("w1_PPROT", {61'd0, PPROT}, 64'b010);
        @(negedge PCLK);
        checkOutput("w1_access_PENABLE", {63'd0, PENABLE}, 64'd1);
        checkOutput("w1_access_PSEL", {61'd0, PSEL}, 64'b001);
        checkOutput("w1_access_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        @(negedge PCLK);
        checkOutput("w1_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        checkOutput("w1_rsp_err", {63'd0, rsp_err}, 64'd0);
        checkOutput("w1_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
        checkOutput("w1_idle_PSEL", {61'd0, PSEL}, 64'd0);
        checkOutput("w1_idle_PENABLE", {63'd0, PENABLE}, 64'd0);
        checkOutput("w1_hold_PADDR", {32'd0, PADDR}, 64'h10);
        @(negedge PCLK);
        checkOutput("w1_stall_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        checkOutput("w1_stall_req_ready", {63'd0, req_ready}, 64'd0);
        popResponse();

        // Read with two wait states
        PREADY = 1'b0;
        PRDATA = 32'h1234_5678;
        applyStimulus(1'b0, 32'h0000_0020, 32'hFFFF_FFFF, 4'b1111, 3'b001, 2'd1, 1'b1);
        checkOutput("r1_PSEL", {61'd0, PSEL}, 64'b010);
        checkOutput("r1_PWRITE", {63'd0, PWRITE}, 64'd0);
        checkOutput("r1_PWDATA", {32'd0, PWDATA}, 64'd0);
        checkOutput("r1_PSTRB", {60'd0, PSTRB}, 64'd0);
        @(negedge PCLK);
        checkOutput("r1_acc1_PENABLE", {63'd0, PENABLE}, 64'd1);
        @(negedge PCLK);
        checkOutput("r1_acc2_PENABLE", {63'd0, PENABLE}, 64'd1);
        checkOutput("r1_acc2_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        @(negedge PCLK);
        checkOutput("r1_acc3_PENABLE", {63'd0, PENABLE}, 64'd1);
        PREADY = 1'b1;
        @(negedge PCLK);
        checkOutput("r1_done_PENABLE", {63'd0, PENABLE}, 64'd0);
        checkOutput("r1_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        checkOutput("r1_rsp_rdata", {32'd0, rsp_rdata}, 64'h1234_5678);
        checkOutput("r1_rsp_err", {63'd0, rsp_err}, 64'd0);
        popResponse();

        // APB3 write: strobes forced all-ones, protection forced zero
        rsp_ready = 1'b1;
        applyStimulus(1'b1, 32'h0000_0030, 32'hA5A5_0001, 4'b0001, 3'b111, 2'd2, 1'b0);
        checkOutput("w3_PSEL", {61'd0, PSEL}, 64'b100);
        checkOutput("w3_PSTRB", {60'd0, PSTRB}, 64'b1111);
        checkOutput("w3_PPROT", {61'd0, PPROT}, 64'd0);
        @(negedge PCLK);
        @(negedge PCLK);
        checkOutput("w3_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        @(negedge PCLK);
        checkOutput("w3_rsp_gone", {63'd0, rsp_valid}, 64'd0);
        checkOutput("w3_req_ready", {63'd0, req_ready}, 64'd1);
        rsp_ready = 1'b0;

        // PSLVERR read, then a back-to-back request blocked until rsp_ready
        PSLVERR = 1'b1;
        PRDATA  = 32'hCAFE_F00D;
        applyStimulus(1'b0, 32'h0000_0040, 32'h0, 4'b0000, 3'b000, 2'd0, 1'b1);
        @(negedge PCLK);
        @(negedge PCLK);
        checkOutput("e1_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        checkOutput("e1_rsp_err", {63'd0, rsp_err}, 64'd1);
        checkOutput("e1_rsp_timeout", {63'd0, rsp_timeout}, 64'd0);
        checkOutput("e1_rsp_rdata", {32'd0, rsp_rdata}, 64'hCAFE_F00D);
        PSLVERR   = 1'b0;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h0000_0050;
        req_wdata = 32'h0BAD_F00D;
        req_strb  = 4'b1111;
        req_sel   = 2'd1;
        apb4_en   = 1'b1;
        @(negedge PCLK);
        checkOutput("b2b_blocked_req_ready", {63'd0, req_ready}, 64'd0);
        checkOutput("b2b_blocked_PSEL", {61'd0, PSEL}, 64'd0);
        checkOutput("b2b_held_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        rsp_ready = 1'b1;
        @(negedge PCLK);
        rsp_ready = 1'b0;
        checkOutput("b2b_rsp_gone", {63'd0, rsp_valid}, 64'd0);
        checkOutput("b2b_req_ready", {63'd0, req_ready}, 64'd1);
        @(negedge PCLK);
        req_valid = 1'b0;
        checkOutput("b2b_setup_PSEL", {61'd0, PSEL}, 64'b010);
        checkOutput("b2b_PADDR", {32'd0, PADDR}, 64'h50);
        checkOutput("b2b_PWRITE", {63'd0, PWRITE}, 64'd1);
        @(negedge PCLK);
        @(negedge PCLK);
        checkOutput("b2b_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        checkOutput("b2b_rsp_err", {63'd0, rsp_err}, 64'd0);
        popResponse();

        // Out-of-range select completes without PREADY, flagged as error
        PREADY = 1'b0;
        applyStimulus(1'b0, 32'h0000_0058, 32'h0, 4'b0000, 3'b000, 2'd3, 1'b1);
        checkOutput("oor_setup_PSEL", {61'd0, PSEL}, 64'd0);
        @(negedge PCLK);
        checkOutput("oor_access_PENABLE", {63'd0, PENABLE}, 64'd1);
        checkOutput("oor_access_PSEL", {61'd0, PSEL}, 64'd0);
        @(negedge PCLK);
        checkOutput("oor_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        checkOutput("oor_rsp_err", {63'd0, rsp_err}, 64'd1);
        popResponse();

        // Stuck PREADY: timeout abort, or indefinite wait in the default build
        PRDATA = 32'h5555_AAAA;
        applyStimulus(1'b0, 32'h0000_0060, 32'h0, 4'b0000, 3'b000, 2'd0, 1'b1);
`ifdef KVIPS_APB_TIMEOUT_EN
        for (int i = 0; i < 8; i++) begin
            @(negedge PCLK);
            checkOutput("to_wait_PENABLE", {63'd0, PENABLE}, 64'd1);
            checkOutput("to_wait_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        end
        @(negedge PCLK);
        checkOutput("to_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        checkOutput("to_rsp_err", {63'd0, rsp_err}, 64'd1);
        checkOutput("to_rsp_timeout", {63'd0, rsp_timeout}, 64'd1);
        checkOutput("to_rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
        checkOutput("to_PSEL", {61'd0, PSEL}, 64'd0);
        checkOutput("to_PENABLE", {63'd0, PENABLE}, 64'd0);
        popResponse();

        // PREADY arriving on the limit cycle completes normally
        applyStimulus(1'b0, 32'h0000_0064, 32'h0, 4'b0000, 3'b000, 2'd0, 1'b1);
        for (int i = 0; i < 7; i++) begin
            @(negedge PCLK);
        end
        @(negedge PCLK);
        checkOutput("tw_last_PENABLE", {63'd0, PENABLE}, 64'd1);
        PREADY = 1'b1;
        @(negedge PCLK);
        checkOutput("tw_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        checkOutput("tw_rsp_timeout", {63'd0, rsp_timeout}, 64'd0);
        checkOutput("tw_rsp_err", {63'd0, rsp_err}, 64'd0);
        checkOutput("tw_rsp_rdata", {32'd0, rsp_rdata}, 64'h5555_AAAA);
        popResponse();
`else
        for (int i = 0; i < 12; i++) begin
            @(negedge PCLK);
            checkOutput("nt_wait_PENABLE", {63'd0, PENABLE}, 64'd1);
            checkOutput("nt_wait_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        end
        PREADY = 1'b1;
        @(negedge PCLK);
        checkOutput("nt_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        checkOutput("nt_rsp_timeout", {63'd0, rsp_timeout}, 64'd0);
        checkOutput("nt_rsp_rdata", {32'd0, rsp_rdata}, 64'h5555_AAAA);
        popResponse();
`endif

        // Reset pulsed during ACCESS drops the transfer immediately
        PREADY = 1'b0;
        applyStimulus(1'b1, 32'h0000_0070, 32'h7777_7777, 4'b1111, 3'b011, 2'd0, 1'b1);
        @(negedge PCLK);
        checkOutput("rst_mid_pre_PENABLE", {63'd0, PENABLE}, 64'd1);
        #2;
        PRESET = 1'b1;
        #1;
        checkOutput("rst_mid_PSEL", {61'd0, PSEL}, 64'd0);
        checkOutput("rst_mid_PENABLE", {63'd0, PENABLE}, 64'd0);
        checkOutput("rst_mid_PADDR", {32'd0, PADDR}, 64'd0);
        @(negedge PCLK);
        checkOutput("rst_mid_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        checkOutput("rst_mid_req_ready", {63'd0, req_ready}, 64'd0);
        PRESET = 1'b0;
        PREADY = 1'b1;
        @(negedge PCLK);
        checkOutput("rst_rel_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        checkOutput("rst_rel_req_ready", {63'd0, req_ready}, 64'd1);
        applyStimulus(1'b1, 32'h0000_0080, 32'h8888_0001, 4'b1100, 3'b000, 2'd2, 1'b1);
        checkOutput("post_rst_PSEL", {61'd0, PSEL}, 64'b100);
        checkOutput("post_rst_PSTRB", {60'd0, PSTRB}, 64'b1100);
        @(negedge PCLK);
        @(negedge PCLK);
        checkOutput("post_rst_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        checkOutput("post_rst_rsp_err", {63'd0, rsp_err}, 64'd0);
        popResponse();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
